hopfield_recall_engine: RTL and testbench
=========================================

Name: hopfield_recall_engine

Overview:
- Parametrised Hopfield associative-recall engine. Holds an N x N signed weight matrix written through a simple port.
- Iterates a bipolar state vector with a single time-multiplexed MAC until the state stops changing or an iteration limit is reached.
- Supports synchronous (whole-vector) and asynchronous (in-place) update modes.
- Successor to the fixed 16-neuron detect/compare datapath; sits between the pattern source and the classification logic.

Parameters:
N, 16, number of neurons (pattern width), N >= 2
WW, 8, signed two's-complement weight width
MAX_ITER, 16, maximum sweeps before forced termination, >= 1
IW, $clog2(N), neuron index width
ACC_W, WW+$clog2(N)+1, accumulator width (derived, never overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  weight write strobe
wr_row  in  IW  weight row i
wr_col  in  IW  weight column j
wr_data  in  WW  signed weight w[i][j]
start  in  1  begin recall
mode_async  in  1  0 = synchronous update, 1 = asynchronous update; sampled at start
pattern_in  in  N  initial state; bit 1 = +1, bit 0 = -1; sampled at start
abort  in  1  cancel a recall in progress
busy  out  1  recall in progress
done  out  1  one-cycle completion pulse
converged  out  1  valid with done; 1 = fixed point reached
pattern_out  out  N  current state vector
iter_count  out  $clog2(MAX_ITER+1)  sweeps completed in the last or current recall

Behaviour:
- Reset: rst is asynchronous and active-high. It clears busy, done, converged, pattern_out, iter_count, the accumulator and all indices, and sets the FSM to IDLE.
- Weight storage is a register array with combinational read and is not reset. Its contents are undefined until written.
- Weight writes:
  - Take effect on the clock edge when wr_en=1 and the FSM is in IDLE.
  - Ignored in any other state.
  - A write and a start in the same cycle: the write lands first and is used by that recall.
- FSM states: IDLE, MAC, UPDATE, CHECK, DONE.
- IDLE:
  - start=1 latches pattern_in into the state register (pattern_out) and mode_async into the mode register.
  - Clears iter_count, changed flag, i, j and acc; goes to MAC. busy=1 from the next cycle.
- MAC (one term per cycle):
  - acc <= acc + (s_j ? w[i][j] : -w[i][j]), sign-extended to ACC_W.
  - s is the state vector; in sync mode s is the snapshot taken at sweep start.
  - j increments; at j=N-1 go to UPDATE.
  - No overflow is possible at ACC_W; no saturation logic.
- UPDATE:
  - New bit = 1 if acc>0, 0 if acc<0, unchanged if acc==0.
  - Sync mode writes the bit to the next-state vector; async mode writes it directly to the state register, so later neurons see it within the same sweep.
  - changed |= (new bit != old bit). Clear acc and j.
  - If i==N-1 go to CHECK, else increment i and return to MAC.
- CHECK:
  - Sync mode commits next-state into the state register. iter_count increments.
  - changed==0: go to DONE with converged=1.
  - Else if iter_count (after increment) == MAX_ITER: go to DONE with converged=0.
  - Else clear changed and i, snapshot the state, and return to MAC.
- DONE: done=1 for exactly one cycle and busy drops, then IDLE. converged, pattern_out and iter_count hold until the next start or reset.
- Sweep latency is N*(N+1)+1 cycles, i.e. 273 for N=16. done rises on the cycle after the final CHECK.
- start while busy: ignored.
- abort in MAC, UPDATE or CHECK: next state is IDLE, busy=0, no done pulse. pattern_out holds its partial state and converged=0. abort takes priority over CHECK's transitions. abort in IDLE or DONE has no effect.
- Reset asserted mid-operation: the engine returns to IDLE immediately; weights are unaffected.

Test Plan:
- All weights 0, pattern_in=16'h1234, sync, start -> all ties keep state; done 274 cycles after start; converged=1, iter_count=1, pattern_out=16'h1234.
- Hebbian store of P=16'hA5A5 (w[i][j]=+1 if p_i==p_j else -1, diagonal 0), pattern_in=16'hA5A4 (1 bit flipped), both modes -> converged=1, pattern_out=16'hA5A5, iter_count=2.
- Only diagonal w[i][i]=-1, others 0, MAX_ITER=8, pattern_in=16'h00FF, sync -> vector inverts every sweep; done with converged=0, iter_count=8, pattern_out=16'h00FF.
- Sync vs async divergence with N=2: w01=w10=-1, diagonal 0, pattern_in=2'b11 -> sync oscillates 11->00->11 until MAX_ITER, converged=0; async reaches 2'b10, converged=1, iter_count=2.
- abort asserted 50 cycles after start -> busy=0 next cycle, no done pulse. A new start then completes normally. A start issued while busy is ignored, and a wr_en issued while busy leaves the weight unchanged, verified by the rerun result.
- rst pulsed mid-MAC (async, between clock edges) -> busy, done, converged, pattern_out and iter_count all 0 immediately. Weights are retained: the rerun of the Hebbian case still converges to 16'hA5A5.

Source files
------------

// File: rtl/hopfield_recall_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hopfield_recall_engine
// Purpose  : Hopfield associative recall using one time-multiplexed MAC;
//            synchronous (whole-vector) or asynchronous (in-place) updates.
// Revision : 1.0 - initial release
// ============================================================================
module hopfield_recall_engine #(
  parameter  int N        = 16,
  parameter  int WW       = 8,
  parameter  int MAX_ITER = 16,
  parameter  int IW       = $clog2(N),
  localparam int ACC_W    = WW + $clog2(N) + 1,
  localparam int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_row,
  input  logic [IW-1:0]        wr_col,
  input  logic signed [WW-1:0] wr_data,
  input  logic                 start,
  input  logic                 mode_async,
  input  logic [N-1:0]         pattern_in,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [N-1:0]         pattern_out,
  output logic [CW-1:0]        iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAC    = 3'd1,
    S_UPDATE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [IW-1:0] c_last_idx = IW'(N - 1);
  localparam logic [CW-1:0] c_max_iter = CW'(MAX_ITER);

  state_t                  r_fsm;
  logic signed [WW-1:0]    r_weights [N][N];
  logic [N-1:0]            r_state;
  logic [N-1:0]            r_next;
  logic                    r_mode;
  logic                    r_changed;
  logic [IW-1:0]           r_i;
  logic [IW-1:0]           r_j;
  logic signed [ACC_W-1:0] r_acc;

  logic signed [WW-1:0]    w_weight;
  logic signed [ACC_W-1:0] w_weight_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_new_bit;
  logic [CW-1:0]           w_iter_next;

  // Weight array is intentionally left without reset.
  always_ff @(posedge clk) begin
    if (wr_en && (r_fsm == S_IDLE)) begin
      r_weights[wr_row][wr_col] <= wr_data;
    end
  end

  // In sync mode r_state is only rewritten at CHECK, so it already is the
  // sweep-start snapshot; in async mode it carries the in-place updates.
  assign w_weight     = r_weights[r_i][r_j];
  assign w_weight_ext = {{(ACC_W - WW){w_weight[WW-1]}}, w_weight};
  assign w_term       = r_state[r_j] ? w_weight_ext : -w_weight_ext;
  assign w_sum        = r_acc + w_term;
  assign w_iter_next  = iter_count + CW'(1);

  always_comb begin
    w_new_bit = r_state[r_i];
    if (r_acc > 0) begin
      w_new_bit = 1'b1;
    end else if (r_acc < 0) begin
      w_new_bit = 1'b0;
    end
  end

  assign pattern_out = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      r_state    <= '0;
      r_next     <= '0;
      r_mode     <= 1'b0;
      r_changed  <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      iter_count <= '0;
    end else begin
      done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (start) begin
            r_state    <= pattern_in;
            r_mode     <= mode_async;
            iter_count <= '0;
            r_changed  <= 1'b0;
            r_i        <= '0;
            r_j        <= '0;
            r_acc      <= '0;
            converged  <= 1'b0;
            busy       <= 1'b1;
            r_fsm      <= S_MAC;
          end
        end

        S_MAC: begin
          if (abort) begin
            busy      <= 1'b0;
            converged <= 1'b0;
            r_fsm     <= S_IDLE;
          end else begin
            r_acc <= w_sum;
            if (r_j == c_last_idx) begin
              r_fsm <= S_UPDATE;
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end

        S_UPDATE: begin
          if (abort) begin
            busy      <= 1'b0;
            converged <= 1'b0;
            r_fsm     <= S_IDLE;
          end else begin
            if (r_mode) begin
              r_state[r_i] <= w_new_bit;
            end else begin
              r_next[r_i] <= w_new_bit;
            end
            r_changed <= r_changed | (w_new_bit != r_state[r_i]);
            r_acc     <= '0;
            r_j       <= '0;
            if (r_i == c_last_idx) begin
              r_fsm <= S_CHECK;
            end else begin
              r_i   <= r_i + IW'(1);
              r_fsm <= S_MAC;
            end
          end
        end

        S_CHECK: begin
          if (abort) begin
            busy      <= 1'b0;
            converged <= 1'b0;
            r_fsm     <= S_IDLE;
          end else begin
            if (!r_mode) begin
              r_state <= r_next;
            end
            iter_count <= w_iter_next;
            if (!r_changed) begin
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              r_fsm     <= S_DONE;
            end else if (w_iter_next == c_max_iter) begin
              converged <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              r_fsm     <= S_DONE;
            end else begin
              r_changed <= 1'b0;
              r_i       <= '0;
              r_fsm     <= S_MAC;
            end
          end
        end

        S_DONE: begin
          r_fsm <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hopfield_recall_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hopfield_recall_engine
// Purpose  : Scoreboard bench for hopfield_recall_engine (N=16, N=16 with
//            MAX_ITER=8, and N=2 instances on shared clock/reset/write bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hopfield_recall_engine;

  localparam int c_sweep16 = 16 * 17 + 1;
  localparam int c_sweep2  = 2 * 3 + 1;

  typedef struct {
    logic [15:0] pat;
    logic        conv;
    int          iter;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_row;
  logic [3:0]  wr_col;
  logic [7:0]  wr_data;
  logic        start;
  logic        mode_async;
  logic        abort;
  logic [15:0] pattern_in;
  int          sel;

  logic        m_busy, m_done, m_conv;
  logic [15:0] m_pat;
  logic [4:0]  m_iter;
  logic        d_busy, d_done, d_conv;
  logic [15:0] d_pat;
  logic [3:0]  d_iter;
  logic        t_busy, t_done, t_conv;
  logic [1:0]  t_pat;
  logic [4:0]  t_iter;

  logic        busy, done, converged;
  logic [15:0] pat_out;
  logic [7:0]  iter_out;

  int   n_checks = 0;
  int   n_errors = 0;
  int   wm [16][16];
  exp_t exp_q [$];

  always #5 clk = ~clk;

  hopfield_recall_engine #(.N(16), .WW(8), .MAX_ITER(16)) u_main (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start && (sel == 0)), .mode_async(mode_async),
    .pattern_in(pattern_in), .abort(abort && (sel == 0)), .busy(m_busy),
    .done(m_done), .converged(m_conv), .pattern_out(m_pat), .iter_count(m_iter)
  );

  hopfield_recall_engine #(.N(16), .WW(8), .MAX_ITER(8)) u_iter8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start && (sel == 1)), .mode_async(mode_async),
    .pattern_in(pattern_in), .abort(abort && (sel == 1)), .busy(d_busy),
    .done(d_done), .converged(d_conv), .pattern_out(d_pat), .iter_count(d_iter)
  );

  hopfield_recall_engine #(.N(2), .WW(8), .MAX_ITER(16)) u_two (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row[0]), .wr_col(wr_col[0]),
    .wr_data(wr_data), .start(start && (sel == 2)), .mode_async(mode_async),
    .pattern_in(pattern_in[1:0]), .abort(abort && (sel == 2)), .busy(t_busy),
    .done(t_done), .converged(t_conv), .pattern_out(t_pat), .iter_count(t_iter)
  );

  always_comb begin
    busy      = m_busy;
    done      = m_done;
    converged = m_conv;
    pat_out   = m_pat;
    iter_out  = {3'b000, m_iter};
    if (sel == 1) begin
      busy      = d_busy;
      done      = d_done;
      converged = d_conv;
      pat_out   = d_pat;
      iter_out  = {4'b0000, d_iter};
    end else if (sel == 2) begin
      busy      = t_busy;
      done      = t_done;
      converged = t_conv;
      pat_out   = {14'b0, t_pat};
      iter_out  = {3'b000, t_iter};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Behavioural recall on the 16-neuron weight image wm, MAX_ITER=16.
  function automatic void model(input logic [15:0] pin, input bit am,
                                output logic [15:0] pout, output bit conv, output int it);
    logic [15:0] s, snap, nx;
    bit          ch, nb;
    int          acc;
    s = pin; conv = 1'b0; it = 0;
    for (int k = 0; k < 16 && !conv; k++) begin
      snap = s; nx = s; ch = 1'b0;
      for (int i = 0; i < 16; i++) begin
        acc = 0;
        for (int j = 0; j < 16; j++) begin
          if (am ? s[j] : snap[j]) acc += wm[i][j];
          else acc -= wm[i][j];
        end
        nb = (acc > 0) ? 1'b1 : (acc < 0) ? 1'b0 : s[i];
        if (nb != s[i]) ch = 1'b1;
        if (am) s[i] = nb;
        else nx[i] = nb;
      end
      if (!am) s = nx;
      it = k + 1;
      if (!ch) conv = 1'b1;
    end
    pout = s;
  endfunction

  task automatic load_weights();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        wr_en = 1'b1; wr_row = i[3:0]; wr_col = j[3:0]; wr_data = wm[i][j][7:0];
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_one(input int i, input int j, input int v);
    @(negedge clk);
    wr_en = 1'b1; wr_row = i[3:0]; wr_col = j[3:0]; wr_data = v[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic hebbian(input logic [15:0] p);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        wm[i][j] = (i == j) ? 0 : ((p[i] == p[j]) ? 1 : -1);
  endtask

  // Push the expectation, start the selected engine, and score it at done.
  task automatic run(input int s, input logic [15:0] pin, input bit am,
                     input logic [15:0] epat, input bit econv, input int eiter,
                     input bit disturb);
    exp_t e, g;
    int   cnt;
    e.pat = epat; e.conv = econv; e.iter = eiter;
    e.lat = eiter * ((s == 2) ? c_sweep2 : c_sweep16);
    exp_q.push_back(e);
    @(negedge clk);
    sel = s; pattern_in = pin; mode_async = am; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pattern_in = ~pin; mode_async = ~am;
    check_eq("busy_after_start", busy, 1);
    cnt = 0;
    while (!done && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      if (disturb && cnt == 20) begin
        start = 1'b1; pattern_in = 16'h0000;
        wr_en = 1'b1; wr_row = 4'd0; wr_col = 4'd1; wr_data = 8'd100;
      end else if (disturb && cnt == 21) begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    g = exp_q.pop_front();
    check_eq("done_seen", done, 1);
    check_eq("latency", cnt, g.lat);
    check_eq("pattern_out", pat_out, g.pat);
    check_eq("converged", converged, g.conv);
    check_eq("iter_count", iter_out, g.iter);
    check_eq("busy_at_done", busy, 0);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("pattern_hold", pat_out, g.pat);
    check_eq("conv_hold", converged, g.conv);
  endtask

  initial begin
    logic [15:0] rp, ep;
    bit          ec;
    int          ei, pulses;

    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    start = 1'b0; mode_async = 1'b0; abort = 1'b0; pattern_in = '0; sel = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_conv", converged, 0);
    check_eq("rst_pattern", pat_out, 0);
    check_eq("rst_iter", iter_out, 0);
    rst = 1'b0;

    // All-zero weights: every accumulator ties, state is kept.
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) wm[i][j] = 0;
    load_weights();
    run(0, 16'h1234, 1'b0, 16'h1234, 1'b1, 1, 1'b0);

    // Hebbian store of A5A5, recall from one flipped bit.
    hebbian(16'hA5A5);
    load_weights();
    run(0, 16'hA5A4, 1'b0, 16'hA5A5, 1'b1, 2, 1'b0);
    run(0, 16'hA5A4, 1'b1, 16'hA5A5, 1'b1, 2, 1'b0);

    // Abort 50 cycles into a recall.
    @(negedge clk);
    sel = 0; pattern_in = 16'hA5A4; mode_async = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_conv", converged, 0);
    check_eq("abort_pattern", pat_out, 16'hA5A4);
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("abort_no_done", pulses, 0);
    check_eq("abort_idle_busy", busy, 0);

    // Rerun with a start and a weight write issued mid-recall; both ignored.
    run(0, 16'hA5A4, 1'b0, 16'hA5A5, 1'b1, 2, 1'b1);

    // Asynchronous reset in the middle of MAC, between clock edges.
    @(negedge clk);
    sel = 0; pattern_in = 16'hA5A4; mode_async = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_conv", converged, 0);
    check_eq("mid_rst_pattern", pat_out, 0);
    check_eq("mid_rst_iter", iter_out, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 16'hA5A4, 1'b1, 16'hA5A5, 1'b1, 2, 1'b0);

    // Random full-range weights, scored against the behavioural model.
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          wm[i][j] = int'($urandom_range(0, 255)) - 128;
      load_weights();
      rp = 16'($urandom);
      model(rp, t[0], ep, ec, ei);
      run(0, rp, t[0], ep, ec, ei, 1'b0);
    end

    // Diagonal -1 only: the vector inverts every sweep until MAX_ITER=8.
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) wm[i][j] = (i == j) ? -1 : 0;
    load_weights();
    run(1, 16'h00FF, 1'b0, 16'h00FF, 1'b0, 8, 1'b0);

    // Two neurons with mutual inhibition: sync oscillates, async settles.
    write_one(0, 0, 0);
    write_one(0, 1, -1);
    write_one(1, 0, -1);
    write_one(1, 1, 0);
    run(2, 16'h0003, 1'b0, 16'h0003, 1'b0, 16, 1'b0);
    run(2, 16'h0003, 1'b1, 16'h0002, 1'b1, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
